// File: rtl/hamming_rx_pipe.sv
// Hamming(15,11) SEC receive pipeline: S1 captures the codeword, S2 adds the syndrome,
// S3 holds the corrected data. All stages freeze together under downstream backpressure.
module hamming_rx_pipe #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [14:0]      in_cw,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [10:0]      out_data,
  output logic             out_err,
  output logic [3:0]       out_syn,
  input  logic             clr_cnt,
  output logic [CNT_W-1:0] word_cnt,
  output logic [CNT_W-1:0] corr_cnt
);

  // XOR of the 1-based indices of every set position.
  function automatic logic [3:0] calc_syn(input logic [14:0] cw);
    logic [3:0] s;
    s = '0;
    for (int i = 1; i <= 15; i++) begin
      if (cw[i-1]) s = s ^ 4'(i);
    end
    return s;
  endfunction

  logic             s1_v_q, s1_v_d;
  logic [14:0]      s1_cw_q, s1_cw_d;
  logic             s2_v_q, s2_v_d;
  logic [14:0]      s2_cw_q, s2_cw_d;
  logic [3:0]       s2_syn_q, s2_syn_d;
  logic             s3_v_q, s3_v_d;
  logic [10:0]      s3_data_q, s3_data_d;
  logic             s3_err_q, s3_err_d;
  logic [3:0]       s3_syn_q, s3_syn_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [CNT_W-1:0] corr_cnt_q, corr_cnt_d;

  logic        stall;
  logic        deliver;
  logic [14:0] flip_mask;
  logic [14:0] fixed_cw;
  logic        unused_parity;

  // Parity positions 1, 2, 4 and 8 carry no payload once the syndrome is known.
  assign unused_parity = ^{fixed_cw[7], fixed_cw[3], fixed_cw[1:0]};

  always_comb begin
    stall     = s3_v_q & ~out_ready;
    deliver   = s3_v_q & out_ready;
    flip_mask = (s2_syn_q != 4'd0) ? (15'(1) << (s2_syn_q - 4'd1)) : 15'd0;
    fixed_cw  = s2_cw_q ^ flip_mask;

    s1_v_d    = s1_v_q;
    s1_cw_d   = s1_cw_q;
    s2_v_d    = s2_v_q;
    s2_cw_d   = s2_cw_q;
    s2_syn_d  = s2_syn_q;
    s3_v_d    = s3_v_q;
    s3_data_d = s3_data_q;
    s3_err_d  = s3_err_q;
    s3_syn_d  = s3_syn_q;

    if (!stall) begin
      s1_v_d    = in_valid;
      s1_cw_d   = in_valid ? in_cw : s1_cw_q;
      s2_v_d    = s1_v_q;
      s2_cw_d   = s1_cw_q;
      s2_syn_d  = calc_syn(s1_cw_q);
      s3_v_d    = s2_v_q;
      s3_data_d = {fixed_cw[14:8], fixed_cw[6:4], fixed_cw[2]};
      s3_err_d  = (s2_syn_q != 4'd0);
      s3_syn_d  = s2_syn_q;
    end

    // Clear takes priority; both counters stick at all-ones.
    word_cnt_d = word_cnt_q;
    corr_cnt_d = corr_cnt_q;
    if (clr_cnt) begin
      word_cnt_d = '0;
      corr_cnt_d = '0;
    end else if (deliver) begin
      if (word_cnt_q != '1) word_cnt_d = word_cnt_q + CNT_W'(1);
      if (s3_err_q && corr_cnt_q != '1) corr_cnt_d = corr_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_v_q     <= 1'b0;
      s1_cw_q    <= '0;
      s2_v_q     <= 1'b0;
      s2_cw_q    <= '0;
      s2_syn_q   <= '0;
      s3_v_q     <= 1'b0;
      s3_data_q  <= '0;
      s3_err_q   <= 1'b0;
      s3_syn_q   <= '0;
      word_cnt_q <= '0;
      corr_cnt_q <= '0;
    end else begin
      s1_v_q     <= s1_v_d;
      s1_cw_q    <= s1_cw_d;
      s2_v_q     <= s2_v_d;
      s2_cw_q    <= s2_cw_d;
      s2_syn_q   <= s2_syn_d;
      s3_v_q     <= s3_v_d;
      s3_data_q  <= s3_data_d;
      s3_err_q   <= s3_err_d;
      s3_syn_q   <= s3_syn_d;
      word_cnt_q <= word_cnt_d;
      corr_cnt_q <= corr_cnt_d;
    end
  end

  assign in_ready  = ~stall;
  assign out_valid = s3_v_q;
  assign out_data  = s3_data_q;
  assign out_err   = s3_err_q;
  assign out_syn   = s3_syn_q;
  assign word_cnt  = word_cnt_q;
  assign corr_cnt  = corr_cnt_q;

endmodule

// File: tb/tb_hamming_rx_pipe.sv
// Directed bench for hamming_rx_pipe: vector table plus stall, reset and saturation sequences.
module tb_hamming_rx_pipe;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [14:0]      in_cw;
  logic             out_valid;
  logic             out_ready;
  logic [10:0]      out_data;
  logic             out_err;
  logic [3:0]       out_syn;
  logic             clr_cnt;
  logic [CNT_W-1:0] word_cnt;
  logic [CNT_W-1:0] corr_cnt;

  hamming_rx_pipe #(.CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .out_syn(out_syn), .clr_cnt(clr_cnt), .word_cnt(word_cnt), .corr_cnt(corr_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference encoder: data bits into non-power-of-two positions, then even parity per index bit.
  function automatic logic [14:0] enc(input logic [10:0] d);
    logic [14:0] c;
    int dp [11];
    logic par;
    dp = '{3, 5, 6, 7, 9, 10, 11, 12, 13, 14, 15};
    c = '0;
    for (int k = 0; k < 11; k++) c[dp[k]-1] = d[k];
    for (int p = 0; p < 4; p++) begin
      par = 1'b0;
      for (int pos = 1; pos <= 15; pos++)
        if ((pos & (1 << p)) != 0) par = par ^ c[pos-1];
      c[(1 << p) - 1] = par;
    end
    return c;
  endfunction

  function automatic logic [14:0] flip(input logic [14:0] cw, input int pos);
    logic [14:0] r;
    r = cw;
    if (pos != 0) r[pos-1] = ~r[pos-1];
    return r;
  endfunction

  typedef struct {
    logic [14:0] cw;
    logic [10:0] data;
    logic        err;
    logic [3:0]  syn;
  } vec_t;

  vec_t        tbl [9];
  logic [10:0] rd [10];
  int          rp [10];
  logic [14:0] rc [10];
  logic [14:0] sw [8];
  logic [10:0] sd [8];
  int          sp [8];
  int          got, last, idx;
  logic        stalled_last;
  logic [10:0] sv_data;
  logic        sv_err;
  logic [3:0]  sv_syn;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{15'h0000, 11'h000, 1'b0, 4'd0};
    tbl[1] = '{15'h7FFF, 11'h7FF, 1'b0, 4'd0};
    tbl[2] = '{15'h7FEF, 11'h7FF, 1'b1, 4'd5};
    tbl[3] = '{15'h7FFE, 11'h7FF, 1'b1, 4'd1};
    tbl[4] = '{15'h3FFF, 11'h7FF, 1'b1, 4'd15};
    tbl[5] = '{15'h0001, 11'h000, 1'b1, 4'd1};
    tbl[6] = '{enc(11'h5A3), 11'h5A3, 1'b0, 4'd0};
    tbl[7] = '{flip(enc(11'h5A3), 8), 11'h5A3, 1'b1, 4'd8};
    tbl[8] = '{flip(enc(11'h001), 3), 11'h001, 1'b1, 4'd3};

    reset = 1'b1; in_valid = 1'b0; in_cw = '0; out_ready = 1'b1; clr_cnt = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_word_cnt", word_cnt, 0);
    chk("rst_corr_cnt", corr_cnt, 0);
    reset = 1'b0;

    // Table: one word at a time, output checked two edges after the accepting edge.
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      in_valid = 1'b1; in_cw = tbl[v].cw;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk($sformatf("vec%0d_latency_early", v), out_valid, 0);
      @(posedge clk);
      @(posedge clk); #1;
      chk($sformatf("vec%0d_valid", v), out_valid, 1);
      chk($sformatf("vec%0d_data", v), out_data, tbl[v].data);
      chk($sformatf("vec%0d_err", v), out_err, tbl[v].err);
      chk($sformatf("vec%0d_syn", v), out_syn, tbl[v].syn);
    end
    @(posedge clk); #1;
    chk("tbl_word_cnt", word_cnt, 9);
    chk("tbl_corr_cnt", corr_cnt, 6);
    @(negedge clk); clr_cnt = 1'b1;
    @(posedge clk); #1;
    chk("clr_word_cnt", word_cnt, 0);
    chk("clr_corr_cnt", corr_cnt, 0);
    clr_cnt = 1'b0;

    // Back-to-back burst of 10 single-error words.
    for (int i = 0; i < 10; i++) begin
      rd[i] = 11'($urandom);
      rp[i] = int'($urandom_range(1, 15));
      rc[i] = flip(enc(rd[i]), rp[i]);
    end
    @(negedge clk);
    got = 0; last = -1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          in_valid = 1'b1; in_cw = rc[i];
          @(negedge clk);
        end
        in_valid = 1'b0;
      end
      begin
        for (int cyc = 0; cyc < 40 && got < 10; cyc++) begin
          @(posedge clk); #1;
          if (out_valid) begin
            chk($sformatf("burst%0d_data", got), out_data, rd[got]);
            chk($sformatf("burst%0d_syn", got), out_syn, rp[got]);
            if (got > 0) chk($sformatf("burst%0d_gap", got), cyc - last, 1);
            last = cyc;
            got++;
          end
        end
      end
    join
    chk("burst_count", got, 10);
    @(posedge clk); #1;
    chk("burst_word_cnt", word_cnt, 10);
    chk("burst_corr_cnt", corr_cnt, 10);
    @(negedge clk); clr_cnt = 1'b1;
    @(negedge clk); clr_cnt = 1'b0;

    // Backpressure: out_ready low for 5 clocks while the source keeps offering words.
    for (int i = 0; i < 8; i++) begin
      sd[i] = 11'(i * 11'h0D3 + 11'h041);
      sp[i] = (i * 2) % 16;
      sw[i] = flip(enc(sd[i]), sp[i]);
    end
    got = 0; idx = 0; stalled_last = 1'b0;
    for (int c = 0; c < 60 && got < 8; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c < 8);
      in_valid  = (idx < 8);
      in_cw     = (idx < 8) ? sw[idx] : 15'd0;
      #1;
      if (stalled_last) begin
        chk($sformatf("stall_c%0d_valid", c), out_valid, 1);
        chk($sformatf("stall_c%0d_frozen_data", c), out_data, sv_data);
        chk($sformatf("stall_c%0d_frozen_err", c), out_err, sv_err);
        chk($sformatf("stall_c%0d_frozen_syn", c), out_syn, sv_syn);
      end else if (out_valid) begin
        chk($sformatf("stall_w%0d_data", got), out_data, sd[got]);
        chk($sformatf("stall_w%0d_syn", got), out_syn, sp[got]);
        got++;
      end
      if (out_valid && !out_ready) chk($sformatf("stall_c%0d_in_ready", c), in_ready, 0);
      if (in_valid && in_ready) idx++;
      sv_data = out_data; sv_err = out_err; sv_syn = out_syn;
      stalled_last = out_valid & ~out_ready;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_count", got, 8);
    @(posedge clk); #1;
    chk("stall_word_cnt", word_cnt, 8);
    chk("stall_corr_cnt", corr_cnt, 7);

    // Asynchronous reset with three words in flight.
    @(negedge clk); in_valid = 1'b1; in_cw = enc(11'h111);
    @(negedge clk); in_cw = enc(11'h222);
    @(negedge clk); in_cw = enc(11'h333);
    @(negedge clk); in_valid = 1'b0;
    #1;
    chk("pre_rst_out_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_word_cnt", word_cnt, 0);
    chk("async_rst_corr_cnt", corr_cnt, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_in_ready", in_ready, 1);
    @(negedge clk); reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk($sformatf("post_rst_flush%0d", i), out_valid, 0);
    end
    @(negedge clk); in_valid = 1'b1; in_cw = flip(enc(11'h6B5), 7);
    @(posedge clk); #1; in_valid = 1'b0;
    chk("post_rst_k0", out_valid, 0);
    @(posedge clk); #1;
    chk("post_rst_k1", out_valid, 0);
    @(posedge clk); #1;
    chk("post_rst_k2_valid", out_valid, 1);
    chk("post_rst_k2_data", out_data, 11'h6B5);
    chk("post_rst_k2_syn", out_syn, 7);

    // Saturation: 20 more corrected words on a 4-bit counter.
    @(negedge clk);
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; in_cw = flip(enc(11'(i)), (i % 15) + 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    chk("sat_word_cnt", word_cnt, 4'hF);
    chk("sat_corr_cnt", corr_cnt, 4'hF);

    // Clear on an edge that also delivers a word.
    in_valid = 1'b1; in_cw = flip(enc(11'h003), 2);
    @(negedge clk); in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("clr_deliver_valid", out_valid, 1);
    clr_cnt = 1'b1;
    @(posedge clk); #1;
    clr_cnt = 1'b0;
    chk("clr_deliver_word_cnt", word_cnt, 0);
    chk("clr_deliver_corr_cnt", corr_cnt, 0);
    chk("clr_deliver_drained", out_valid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
